// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the single-issue NPC core: owns the PC, fetches over a
// valid/ready port, then steps decode, execute and writeback; stops on ebreak or fault.
module core_seq_ctrl #(
  parameter int unsigned           PC_WIDTH      = 32,
  parameter int unsigned           INST_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC      = 32'h8000_0000,
  parameter int unsigned           FETCH_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  is_ebreak,
  output logic                  ex_start,
  input  logic                  ex_done,
  input  logic                  ex_redirect,
  input  logic [PC_WIDTH-1:0]   ex_target,
  output logic                  rf_wen,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [63:0]           instret,
  output logic                  halted,
  output logic                  fault
);

  localparam int unsigned      TimerW      = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetchReq,
    StFetchRsp,
    StDecode,
    StExec,
    StWb,
    StHalt,
    StErr
  } state_e;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [PC_WIDTH-1:0]     next_pc_q;
  logic [PC_WIDTH-1:0]     next_pc;
  logic [INST_WIDTH-1:0]   inst_q;
  logic [63:0]             instret_q;
  logic [TimerW-1:0]       timer_q;
  logic                    req_valid_q;
  logic                    inst_valid_q;
  logic                    rf_wen_q;
  logic                    halted_q;
  logic                    fault_q;

  assign next_pc = ex_redirect ? ex_target : pc_q + PC_WIDTH'(4);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetchReq: if (imem_req_ready) state_d = StFetchRsp;
      StFetchRsp: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (imem_rsp_valid)              state_d = StDecode;
        else if (timer_q == TimeoutLast) state_d = StErr;
      end
      StDecode:   state_d = is_ebreak ? StHalt : StExec;
      StExec: begin
        if (ex_done) state_d = (next_pc[1:0] != 2'b00) ? StErr : StWb;
      end
      StWb:       state_d = StFetchReq;
      default:    state_d = state_q;
    endcase
  end

  // Moore flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetchReq;
      pc_q         <= RESET_PC;
      next_pc_q    <= '0;
      inst_q       <= '0;
      instret_q    <= '0;
      timer_q      <= '0;
      req_valid_q  <= 1'b1;
      inst_valid_q <= 1'b0;
      rf_wen_q     <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= (state_d == StFetchReq);
      inst_valid_q <= (state_d == StDecode);
      rf_wen_q     <= (state_d == StWb);
      halted_q     <= (state_d == StHalt);
      fault_q      <= (state_d == StErr);
      case (state_q)
        StFetchReq: timer_q <= '0;
        StFetchRsp: begin
          timer_q <= timer_q + 1'b1;
          if (imem_rsp_valid) inst_q <= imem_rsp_data;
        end
        StExec:     if (ex_done) next_pc_q <= next_pc;
        StWb: begin
          pc_q      <= next_pc_q;
          instret_q <= instret_q + 64'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = inst_valid_q;
  assign ex_start       = inst_valid_q & ~is_ebreak;
  assign rf_wen         = rf_wen_q;
  assign pc             = pc_q;
  assign instret        = instret_q;
  assign halted         = halted_q;
  assign fault          = fault_q;

endmodule
